// File: rtl/dmac_ahb_pkg.sv
// Shared AHB-Lite encodings and helpers for the DMAC responder memory.
package dmac_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'b00,
        HSIZE_HALF = 2'b01,
        HSIZE_WORD = 2'b10,
        HSIZE_BAD  = 2'b11
    } hsize_e;

    // Codebase burst encoding: only fixed-length incrementing bursts exist.
    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR4  = 3'b001,
        HBURST_INCR8  = 3'b010,
        HBURST_INCR16 = 3'b011
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // Number of beats in a burst; illegal encodings are rejected before use.
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE: return 5'd1;
            HBURST_INCR4:  return 5'd4;
            HBURST_INCR8:  return 5'd8;
            HBURST_INCR16: return 5'd16;
            default:       return 5'd1;
        endcase
    endfunction

    // Byte lanes addressed by a transfer of the given size at byte offset a.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] m;
        case (size)
            HSIZE_BYTE: m = 4'b0001 << a;
            HSIZE_HALF: m = a[1] ? 4'b1100 : 4'b0011;
            default:    m = 4'b1111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ahb_slave_sram.sv
// DEPTH x 32 storage: combinational read port, synchronous byte-enabled write port.
module ahb_slave_sram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [3:0]               we,
    input  logic [31:0]              wdata
);

    logic [31:0] mem [DEPTH];

    assign rdata = mem[raddr];

    // Per-byte write; storage is never cleared, not even by reset.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/dmac_ahb_slave_mem.sv
// AHB-Lite responder memory: pipelined accept, programmable wait states,
// fixed-length incrementing bursts, two-cycle ERROR responses.
module dmac_ahb_slave_mem
    import dmac_ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [1:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  HWSTRB,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned ADDR_W    = $clog2(DEPTH) + 2;
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES - 1);

    slave_state_e state_q, state_d;
    logic [3:0]   wait_q, wait_d;

    // Data-phase copy of the accepted address phase
    logic [ADDR_W-1:0] d_off_q;
    logic              d_write_q;
    logic [1:0]        d_size_q;

    // Burst tracking
    logic              burst_open_q;
    logic [3:0]        beats_left_q;
    logic [31:0]       prev_addr_q;

    logic [31:0]       hrdata_q;

    // Address-phase decode
    logic              addr_slot;
    logic              accept;
    logic [32:0]       diff;
    logic              err_range, err_size, err_align, err_burst, err_seq;
    logic              acc_ok, acc_bad;

    // Memory access
    logic              commit;
    logic [3:0]        wr_en;
    logic              load_rd;
    logic [ADDR_W-3:0] rd_idx;
    logic [31:0]       mem_rdata;
    logic [31:0]       rd_word;

    // Address phases are only sampled in states that complete a data phase (or idle)
    assign addr_slot = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    assign accept    = HSEL & HREADY & HTRANS[1] & addr_slot;

    // Borrow bit of the subtraction flags addresses below the base
    assign diff      = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign err_range = diff[32] || (diff[31:0] >= SPAN);
    assign err_size  = (HSIZE == HSIZE_BAD);
    assign err_align = ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                       ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));
    assign err_burst = HBURST[2];
    assign err_seq   = (HTRANS == HTRANS_SEQ) &&
                       (!burst_open_q || (HADDR != prev_addr_q + 32'd4));
    assign acc_bad   = accept &  (err_range | err_size | err_align | err_burst | err_seq);
    assign acc_ok    = accept & ~(err_range | err_size | err_align | err_burst | err_seq);

    // Next-state, wait counter and response outputs
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                if (wait_q == 4'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
        if (addr_slot) begin
            if (acc_bad) begin
                state_d = ST_ERR1;
            end else if (acc_ok) begin
                if (WAIT_STATES != 0) begin
                    state_d = ST_WAIT;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = ST_DATA;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // FSM state and wait counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Latch the accepted address phase for use in the data phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            d_off_q   <= '0;
            d_write_q <= 1'b0;
            d_size_q  <= '0;
        end else if (acc_ok) begin
            d_off_q   <= diff[ADDR_W-1:0];
            d_write_q <= HWRITE;
            d_size_q  <= HSIZE;
        end
    end

    // Burst bookkeeping: NONSEQ (re)opens, SEQ counts down, any error closes
    always_ff @(posedge clk) begin
        if (!rst) begin
            burst_open_q <= 1'b0;
            beats_left_q <= '0;
            prev_addr_q  <= '0;
        end else if (acc_bad) begin
            burst_open_q <= 1'b0;
        end else if (acc_ok) begin
            prev_addr_q <= HADDR;
            if (HTRANS == HTRANS_NONSEQ) begin
                beats_left_q <= 4'(burst_len(HBURST) - 5'd1);
                burst_open_q <= (HBURST != HBURST_SINGLE);
            end else begin
                beats_left_q <= beats_left_q - 4'd1;
                burst_open_q <= (beats_left_q != 4'd1);
            end
        end
    end

    // Writes commit only in DATA; reset in that cycle drops the write
    assign commit = (state_q == ST_DATA) && d_write_q && rst;
    assign wr_en  = commit ? (HWSTRB & lane_mask(d_size_q, d_off_q[1:0])) : 4'b0000;

    // Read word is fetched the cycle before its DATA phase: at accept with no
    // waits, otherwise in the last WAIT cycle from the latched address
    assign load_rd = (acc_ok && (WAIT_STATES == 0) && !HWRITE) ||
                     ((state_q == ST_WAIT) && (wait_q == 4'd0) && !d_write_q);
    assign rd_idx  = (state_q == ST_WAIT) ? d_off_q[ADDR_W-1:2] : diff[ADDR_W-1:2];

    ahb_slave_sram #(
        .DEPTH(DEPTH)
    ) u_sram (
        .clk  (clk),
        .raddr(rd_idx),
        .rdata(mem_rdata),
        .waddr(d_off_q[ADDR_W-1:2]),
        .we   (wr_en),
        .wdata(HWDATA)
    );

    // Bypass: a read fetched while the same word is being written sees the new bytes
    always_comb begin
        rd_word = mem_rdata;
        if (commit && (rd_idx == d_off_q[ADDR_W-1:2])) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (wr_en[b]) begin
                    rd_word[8*b +: 8] = HWDATA[8*b +: 8];
                end
            end
        end
    end

    // Read data register; holds outside read data phases
    always_ff @(posedge clk) begin
        if (!rst) begin
            hrdata_q <= '0;
        end else if (load_rd) begin
            hrdata_q <= rd_word;
        end
    end

    assign HRDATA = hrdata_q;

endmodule
